matmul_host_driver: RTL and testbench
=====================================

// Module: matmul_host_driver
// PURPOSE
//  Initiator for the matmul accelerator's MMIO/DMA target interface: drives the accelerator's
//  mmio_*/dma_* inputs and consumes its mmio_r_data/dma_r_data outputs.
//  Per job: checks accelerator size, DMA-writes A then B from an input stream, sets the control
//  bit, polls it until it clears, then DMA-reads the result into an output stream.
//  Used as the bench/host-side model and as the on-chip sequencer in front of the accelerator.
// PARAMETERS
//  MMIO_WIDTH    32          MMIO data width
//  MMIO_ADDRBITS 32          MMIO address width
//  DMA_WIDTH     256         DMA beat width; BEAT_BYTES = DMA_WIDTH/8
//  DMA_ADDRBITS  32          DMA byte-address width
//  MUL_SIZE      8           matrix dimension; MEMSZ = MUL_SIZE*MUL_SIZE*8/DMA_WIDTH beats per matrix
//  OFF_INA       262144      DMA byte base of A
//  OFF_INB       524288      DMA byte base of B
//  OFF_OUT       786432      DMA byte base of result
//  POLL_MAX      1024        max status polls before error
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst          in   1              synchronous, active-low reset
//  start        in   1              job start pulse, ignored while busy
//  busy         out  1              job in progress
//  done         out  1              1-cycle pulse: job completed
//  err          out  1              sticky: size mismatch or poll timeout
//  in_valid     in   1              A/B beat valid
//  in_ready     out  1              A/B beat accepted when in_valid&&in_ready
//  in_data      in   DMA_WIDTH      A/B beat (first MEMSZ beats are A, next MEMSZ beats are B)
//  out_valid    out  1              result beat valid
//  out_ready    in   1              result beat consumed when out_valid&&out_ready
//  out_data     out  DMA_WIDTH      result beat
//  mmio_w_req   out  1              MMIO write strobe
//  mmio_w_addr  out  MMIO_ADDRBITS  MMIO write address
//  mmio_w_data  out  MMIO_WIDTH     MMIO write data
//  mmio_r_req   out  1              MMIO read strobe
//  mmio_r_addr  out  MMIO_ADDRBITS  MMIO read address
//  mmio_r_data  in   MMIO_WIDTH     MMIO read data, valid the cycle after mmio_r_req
//  dma_w_req    out  1              DMA write strobe
//  dma_w_addr   out  DMA_ADDRBITS   DMA write byte address
//  dma_w_data   out  DMA_WIDTH      DMA write data
//  dma_r_req    out  1              DMA read strobe
//  dma_r_addr   out  DMA_ADDRBITS   DMA read byte address
//  dma_r_data   in   DMA_WIDTH      DMA read data, valid the cycle after dma_r_req
// BEHAVIOUR
//  - Reset (rst==0 at an edge):
//    - state=IDLE; all *_req, busy, done, err, in_ready, out_valid = 0
//    - all addr/data outputs = 0
//    - an in-flight job is abandoned; no req is issued after reset.
//  - All outputs are registered except in_ready, which is 1 exactly in LOAD_A/LOAD_B.
//  - Every *_req is a 1-cycle pulse. At most one MMIO or DMA read is outstanding.
//  - IDLE: start accepted -> clear err, busy=1, go to SZ.
//  - SZ: pulse mmio_r_req, addr 0x00. Next cycle compare full mmio_r_data to MUL_SIZE:
//    - not equal -> ERR
//    - equal -> LOAD_A, idx=0.
//  - LOAD_A / LOAD_B: per accepted beat, the next cycle drives dma_w_req=1 with
//    addr = base + idx*BEAT_BYTES (base = OFF_INA or OFF_INB) and data = the beat; idx++.
//    - idx==MEMSZ after A -> LOAD_B, idx=0
//    - idx==MEMSZ after B -> GO
//    - in_valid low stalls with no penalty.
//  - GO: pulse mmio_w_req, addr 0x08, data 1 -> POLL, pollcnt=0.
//  - POLL: pulse mmio_r_req, addr 0x08; sample bit0 next cycle:
//    - bit0=1: pollcnt++; reissue the next cycle; pollcnt==POLL_MAX -> ERR
//    - bit0=0 -> RD, idx=0.
//    - A 1 on the first poll is legal.
//  - RD: pulse dma_r_req, addr OFF_OUT + idx*BEAT_BYTES.
//    - Next cycle: out_data = dma_r_data, out_valid = 1.
//    - out_valid and out_data hold until out_ready; then idx++ and issue the next read
//      the following cycle.
//    - idx==MEMSZ -> DONE.
//  - DONE: done=1 for one cycle, busy=0 -> IDLE.
//  - ERR: err=1 (sticky until the next accepted start), busy=0, done stays 0 -> IDLE.
//  - Addresses: computed in 32 bits, truncated to the *_ADDRBITS width. Counters: idx width
//    clog2(MEMSZ+1); pollcnt width clog2(POLL_MAX+1); neither wraps.
//  - start while busy (including the same cycle as done or err): ignored.
// TESTING (defaults: MEMSZ=2, BEAT_BYTES=32)
//  - Happy path: mmio_r_data=8, two A beats and two B beats, status 1 then 0, two result
//    beats R0/R1 -> dma_w at 0x40000, 0x40020, 0x80000, 0x80020; write 0x08=1; dma_r at
//    0xC0000, 0xC0020; out beats R0, R1; done pulses once; err=0.
//  - Size mismatch: mmio_r_data=4 -> err=1, busy=0, no dma_w_req ever.
//  - Backpressure: in_valid toggles every other cycle and out_ready is held low 5 cycles ->
//    no beat lost or duplicated; out_data stable while stalled; 2nd dma_r_req only after
//    the 1st out handshake.
//  - Timeout: status bit0 stuck at 1 with POLL_MAX=4 -> exactly 4 polls, then err=1; the next
//    start clears err.
//  - Reset mid-LOAD_B: rst=0 for one cycle -> all outputs 0 next cycle; a fresh start runs a
//    full job correctly.
//  - start pulsed during POLL -> ignored; exactly one done.

Source files
------------

// File: rtl/matmul_host_driver_if.sv
// Host-side bundle between matmul_host_driver and its job stream, result stream and accelerator MMIO/DMA target.
// master = sequencer side; slave = environment (job source, result sink, accelerator).
interface matmul_host_driver_if #(
   parameter int MMIO_WIDTH    = 32,
   parameter int MMIO_ADDRBITS = 32,
   parameter int DMA_WIDTH     = 256,
   parameter int DMA_ADDRBITS  = 32
);
   logic                     start;
   logic                     busy;
   logic                     done;
   logic                     err;
   logic                     in_valid;
   logic                     in_ready;
   logic [DMA_WIDTH-1:0]     in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [DMA_WIDTH-1:0]     out_data;
   logic                     mmio_w_req;
   logic [MMIO_ADDRBITS-1:0] mmio_w_addr;
   logic [MMIO_WIDTH-1:0]    mmio_w_data;
   logic                     mmio_r_req;
   logic [MMIO_ADDRBITS-1:0] mmio_r_addr;
   logic [MMIO_WIDTH-1:0]    mmio_r_data;
   logic                     dma_w_req;
   logic [DMA_ADDRBITS-1:0]  dma_w_addr;
   logic [DMA_WIDTH-1:0]     dma_w_data;
   logic                     dma_r_req;
   logic [DMA_ADDRBITS-1:0]  dma_r_addr;
   logic [DMA_WIDTH-1:0]     dma_r_data;

   modport master (
      input  start, output busy, output done, output err,
      input  in_valid, output in_ready, input in_data,
      output out_valid, input out_ready, output out_data,
      output mmio_w_req, output mmio_w_addr, output mmio_w_data,
      output mmio_r_req, output mmio_r_addr, input mmio_r_data,
      output dma_w_req, output dma_w_addr, output dma_w_data,
      output dma_r_req, output dma_r_addr, input dma_r_data
   );

   modport slave (
      output start, input busy, input done, input err,
      output in_valid, input in_ready, output in_data,
      input  out_valid, output out_ready, input out_data,
      input  mmio_w_req, input mmio_w_addr, input mmio_w_data,
      input  mmio_r_req, input mmio_r_addr, output mmio_r_data,
      input  dma_w_req, input dma_w_addr, input dma_w_data,
      input  dma_r_req, input dma_r_addr, output dma_r_data
   );
endinterface

// File: rtl/matmul_host_driver.sv
// Job sequencer for the matmul accelerator: size check, DMA-load A/B, kick, poll, DMA-read result.
// Registered outputs (in_ready excepted); in_valid/out_ready low simply stall, one read in flight at a time.
module matmul_host_driver #(
   parameter int MMIO_WIDTH    = 32,
   parameter int MMIO_ADDRBITS = 32,
   parameter int DMA_WIDTH     = 256,
   parameter int DMA_ADDRBITS  = 32,
   parameter int MUL_SIZE      = 8,
   parameter int OFF_INA       = 262144,
   parameter int OFF_INB       = 524288,
   parameter int OFF_OUT       = 786432,
   parameter int POLL_MAX      = 1024
) (
   input logic                 clk,
   input logic                 rst,
   matmul_host_driver_if.master bus
);
   localparam int BEAT_BYTES = DMA_WIDTH / 8;
   localparam int MEMSZ      = MUL_SIZE * MUL_SIZE * 8 / DMA_WIDTH;
   localparam int IW         = $clog2(MEMSZ + 1);
   localparam int PW         = $clog2(POLL_MAX + 1);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_SZ        = 4'd1;
   localparam logic [3:0] S_SZ_WAIT   = 4'd2;
   localparam logic [3:0] S_SZ_CHK    = 4'd3;
   localparam logic [3:0] S_LOAD_A    = 4'd4;
   localparam logic [3:0] S_LOAD_B    = 4'd5;
   localparam logic [3:0] S_GO        = 4'd6;
   localparam logic [3:0] S_POLL      = 4'd7;
   localparam logic [3:0] S_POLL_WAIT = 4'd8;
   localparam logic [3:0] S_POLL_CHK  = 4'd9;
   localparam logic [3:0] S_RD        = 4'd10;
   localparam logic [3:0] S_RD_WAIT   = 4'd11;
   localparam logic [3:0] S_RD_CAP    = 4'd12;
   localparam logic [3:0] S_RD_HOLD   = 4'd13;
   localparam logic [3:0] S_DONE      = 4'd14;
   localparam logic [3:0] S_ERR       = 4'd15;

   logic [3:0]    state;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_nxt;
   logic [PW-1:0] pollcnt;
   logic [PW-1:0] pollcnt_nxt;
   logic          fin;
   logic          load_hs;

   function automatic logic [31:0] beat_addr(input int base, input logic [IW-1:0] i);
      return 32'(base) + 32'(i) * 32'(BEAT_BYTES);
   endfunction

   assign bus.in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
   assign load_hs      = bus.in_valid && bus.in_ready;
   assign idx_nxt      = idx + IW'(1);
   assign pollcnt_nxt  = pollcnt + PW'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= S_IDLE;
         idx             <= '0;
         pollcnt         <= '0;
         fin             <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
         bus.out_valid   <= 1'b0;
         bus.out_data    <= '0;
         bus.mmio_w_req  <= 1'b0;
         bus.mmio_w_addr <= '0;
         bus.mmio_w_data <= '0;
         bus.mmio_r_req  <= 1'b0;
         bus.mmio_r_addr <= '0;
         bus.dma_w_req   <= 1'b0;
         bus.dma_w_addr  <= '0;
         bus.dma_w_data  <= '0;
         bus.dma_r_req   <= 1'b0;
         bus.dma_r_addr  <= '0;
      end else begin
         bus.done       <= 1'b0;
         bus.mmio_w_req <= 1'b0;
         bus.mmio_r_req <= 1'b0;
         bus.dma_w_req  <= 1'b0;
         bus.dma_r_req  <= 1'b0;
         // fin blocks a start landing in the same cycle as the done/err report
         fin            <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start && !fin) begin
                  bus.err  <= 1'b0;
                  bus.busy <= 1'b1;
                  state    <= S_SZ;
               end
            end
            S_SZ: begin
               bus.mmio_r_req  <= 1'b1;
               bus.mmio_r_addr <= '0;
               state           <= S_SZ_WAIT;
            end
            S_SZ_WAIT: state <= S_SZ_CHK;
            S_SZ_CHK: begin
               if (bus.mmio_r_data == MMIO_WIDTH'(MUL_SIZE)) begin
                  idx   <= '0;
                  state <= S_LOAD_A;
               end else begin
                  state <= S_ERR;
               end
            end
            S_LOAD_A, S_LOAD_B: begin
               if (load_hs) begin
                  bus.dma_w_req  <= 1'b1;
                  bus.dma_w_addr <= DMA_ADDRBITS'(beat_addr((state == S_LOAD_B) ? OFF_INB : OFF_INA, idx));
                  bus.dma_w_data <= bus.in_data;
                  if (idx_nxt == IW'(MEMSZ)) begin
                     idx   <= '0;
                     state <= (state == S_LOAD_A) ? S_LOAD_B : S_GO;
                  end else begin
                     idx <= idx_nxt;
                  end
               end
            end
            S_GO: begin
               bus.mmio_w_req  <= 1'b1;
               bus.mmio_w_addr <= MMIO_ADDRBITS'(8);
               bus.mmio_w_data <= MMIO_WIDTH'(1);
               pollcnt         <= '0;
               state           <= S_POLL;
            end
            S_POLL: begin
               bus.mmio_r_req  <= 1'b1;
               bus.mmio_r_addr <= MMIO_ADDRBITS'(8);
               state           <= S_POLL_WAIT;
            end
            S_POLL_WAIT: state <= S_POLL_CHK;
            S_POLL_CHK: begin
               if (bus.mmio_r_data[0]) begin
                  pollcnt <= pollcnt_nxt;
                  if (pollcnt_nxt == PW'(POLL_MAX)) begin
                     state <= S_ERR;
                  end else begin
                     bus.mmio_r_req <= 1'b1;
                     state          <= S_POLL_WAIT;
                  end
               end else begin
                  idx   <= '0;
                  state <= S_RD;
               end
            end
            S_RD: begin
               bus.dma_r_req  <= 1'b1;
               bus.dma_r_addr <= DMA_ADDRBITS'(beat_addr(OFF_OUT, idx));
               state          <= S_RD_WAIT;
            end
            S_RD_WAIT: state <= S_RD_CAP;
            S_RD_CAP: begin
               bus.out_data  <= bus.dma_r_data;
               bus.out_valid <= 1'b1;
               state         <= S_RD_HOLD;
            end
            S_RD_HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  idx           <= idx_nxt;
                  if (idx_nxt == IW'(MEMSZ)) begin
                     state <= S_DONE;
                  end else begin
                     bus.dma_r_req  <= 1'b1;
                     bus.dma_r_addr <= DMA_ADDRBITS'(beat_addr(OFF_OUT, idx_nxt));
                     state          <= S_RD_WAIT;
                  end
               end
            end
            S_DONE: begin
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               fin      <= 1'b1;
               state    <= S_IDLE;
            end
            S_ERR: begin
               bus.err  <= 1'b1;
               bus.busy <= 1'b0;
               fin      <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_host_driver.sv
// Directed job scenarios with random payloads against an accelerator model and an address/ordering reference.
module tb_matmul_host_driver;
   localparam int MMIO_WIDTH    = 32;
   localparam int MMIO_ADDRBITS = 32;
   localparam int DMA_WIDTH     = 256;
   localparam int DMA_ADDRBITS  = 32;
   localparam int MUL_SIZE      = 8;
   localparam int POLL_MAX      = 4;
   localparam int MEMSZ         = MUL_SIZE * MUL_SIZE * 8 / DMA_WIDTH;
   localparam int BB            = DMA_WIDTH / 8;
   localparam logic [31:0] OFF_INA = 32'h0004_0000;
   localparam logic [31:0] OFF_INB = 32'h0008_0000;
   localparam logic [31:0] OFF_OUT = 32'h000C_0000;

   typedef logic [DMA_WIDTH-1:0] beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   matmul_host_driver_if #(
      .MMIO_WIDTH(MMIO_WIDTH), .MMIO_ADDRBITS(MMIO_ADDRBITS),
      .DMA_WIDTH(DMA_WIDTH), .DMA_ADDRBITS(DMA_ADDRBITS)
   ) bus ();

   matmul_host_driver #(
      .MMIO_WIDTH(MMIO_WIDTH), .MMIO_ADDRBITS(MMIO_ADDRBITS),
      .DMA_WIDTH(DMA_WIDTH), .DMA_ADDRBITS(DMA_ADDRBITS),
      .MUL_SIZE(MUL_SIZE), .OFF_INA(262144), .OFF_INB(524288),
      .OFF_OUT(786432), .POLL_MAX(POLL_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   // accelerator model state
   logic [31:0] size_val = 32'd8;
   bit          status_q[$];
   bit          status_stuck = 1'b0;
   beat_t       result_mem [MEMSZ];
   bit          mr_pend = 1'b0;
   bit          dr_pend = 1'b0;
   logic [31:0] mr_addr = '0;
   logic [31:0] dr_addr = '0;

   // observation logs
   logic [31:0] dw_addr_q[$];
   beat_t       dw_data_q[$];
   logic [31:0] mw_addr_q[$];
   logic [31:0] mw_data_q[$];
   logic [31:0] dr_addr_q[$];
   int          dr_outs_q[$];
   beat_t       out_q[$];
   int          done_count = 0;
   int          poll_count = 0;
   int          size_reads = 0;
   int          out_hs = 0;
   int          stall_viol = 0;

   // stimulus/reference
   beat_t in_q[$];
   beat_t exp_in[$];
   bit    job_over = 1'b0;
   bit    to_flag = 1'b0;

   always @(negedge clk) begin
      int k;
      if (mr_pend) begin
         if (mr_addr == 32'h0) bus.mmio_r_data = size_val;
         else if (status_q.size() > 0) bus.mmio_r_data = {31'b0, status_q.pop_front()};
         else bus.mmio_r_data = {31'b0, status_stuck};
      end else begin
         bus.mmio_r_data = 32'h5A5A_A5A4;
      end
      k = int'((dr_addr - OFF_OUT) / BB);
      if (dr_pend && dr_addr >= OFF_OUT && k < MEMSZ) bus.dma_r_data = result_mem[k];
      else bus.dma_r_data = {8{32'hBAD0_0BAD}};
      mr_pend = bus.mmio_r_req;
      mr_addr = bus.mmio_r_addr;
      dr_pend = bus.dma_r_req;
      dr_addr = bus.dma_r_addr;
      if (bus.mmio_r_req) begin
         if (bus.mmio_r_addr == 32'h8) poll_count++;
         else size_reads++;
      end
      if (bus.mmio_w_req) begin
         mw_addr_q.push_back(bus.mmio_w_addr);
         mw_data_q.push_back(bus.mmio_w_data);
      end
      if (bus.dma_w_req) begin
         dw_addr_q.push_back(bus.dma_w_addr);
         dw_data_q.push_back(bus.dma_w_data);
      end
      if (bus.dma_r_req) begin
         dr_addr_q.push_back(bus.dma_r_addr);
         dr_outs_q.push_back(out_hs);
      end
      if (bus.done) done_count++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      dw_addr_q.delete(); dw_data_q.delete();
      mw_addr_q.delete(); mw_data_q.delete();
      dr_addr_q.delete(); dr_outs_q.delete();
      out_q.delete();
      done_count = 0; poll_count = 0; size_reads = 0;
      out_hs = 0; stall_viol = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctl"}, {bus.busy, bus.done, bus.err, bus.in_ready, bus.out_valid,
                            bus.mmio_w_req, bus.mmio_r_req, bus.dma_w_req, bus.dma_r_req}, '0);
      check({tag, "_addr"}, {bus.mmio_w_addr, bus.mmio_r_addr, bus.dma_w_addr, bus.dma_r_addr}, '0);
      check({tag, "_mwdata"}, bus.mmio_w_data, '0);
      check({tag, "_dwdata"}, bus.dma_w_data, '0);
      check({tag, "_outdata"}, bus.out_data, '0);
   endtask

   task automatic make_payload();
      beat_t b;
      in_q.delete(); exp_in.delete();
      for (int i = 0; i < 2 * MEMSZ; i++) begin
         for (int w = 0; w < DMA_WIDTH / 32; w++) b[w*32 +: 32] = $urandom;
         in_q.push_back(b);
         exp_in.push_back(b);
      end
      for (int i = 0; i < MEMSZ; i++) begin
         for (int w = 0; w < DMA_WIDTH / 32; w++) b[w*32 +: 32] = $urandom;
         result_mem[i] = b;
      end
   endtask

   task automatic feed(input bit toggle);
      int cyc = 0;
      while (in_q.size() > 0 && !job_over) begin
         @(negedge clk);
         bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         bus.in_data  = in_q[0];
         #1;
         if (bus.in_valid && bus.in_ready) void'(in_q.pop_front());
         cyc++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int stall);
      int    vcnt = 0;
      bit    prev_stalled = 1'b0;
      beat_t held = '0;
      while (!job_over && out_q.size() < MEMSZ) begin
         @(negedge clk);
         bus.out_ready = (vcnt >= stall);
         #1;
         if (bus.out_valid) begin
            vcnt++;
            if (prev_stalled && bus.out_data !== held) stall_viol++;
            if (bus.out_ready) begin
               out_q.push_back(bus.out_data);
               out_hs++;
               prev_stalled = 1'b0;
            end else begin
               prev_stalled = 1'b1;
               held = bus.out_data;
            end
         end else begin
            if (prev_stalled) stall_viol++;
            prev_stalled = 1'b0;
         end
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n = 0;
      while (!(bus.done === 1'b1 || bus.err === 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      to_flag  = (n >= budget);
      job_over = 1'b1;
   endtask

   task automatic poke_start();
      int n = 0;
      while (poll_count < 1 && !job_over && n < 400) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic run_job(input string tag, input logic [31:0] sz, input bit toggle,
                          input int stall, input bit poke);
      make_payload();
      size_val = sz;
      clear_logs();
      job_over = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_busy_err_on_start"}, {bus.busy, bus.err}, 2'b10);
      fork
         feed(toggle);
         drain(stall);
         wait_end(600);
         if (poke) poke_start();
      join
      repeat (5) @(negedge clk);
      check({tag, "_no_timeout"}, to_flag, 1'b0);
   endtask

   task automatic check_job(input string tag, input int polls);
      logic [31:0] ea;
      check({tag, "_dw_n"}, dw_addr_q.size(), 2 * MEMSZ);
      for (int i = 0; i < dw_addr_q.size() && i < 2 * MEMSZ; i++) begin
         ea = (i < MEMSZ) ? OFF_INA + 32'(i * BB) : OFF_INB + 32'((i - MEMSZ) * BB);
         check($sformatf("%s_dw_addr%0d", tag, i), dw_addr_q[i], ea);
         check($sformatf("%s_dw_data%0d", tag, i), dw_data_q[i], exp_in[i]);
      end
      check({tag, "_mw_n"}, mw_addr_q.size(), 1);
      if (mw_addr_q.size() > 0) check({tag, "_mw"}, {mw_addr_q[0], mw_data_q[0]}, {32'h8, 32'h1});
      check({tag, "_polls"}, poll_count, polls);
      check({tag, "_dr_n"}, dr_addr_q.size(), MEMSZ);
      for (int i = 0; i < dr_addr_q.size() && i < MEMSZ; i++) begin
         check($sformatf("%s_dr_addr%0d", tag, i), dr_addr_q[i], OFF_OUT + 32'(i * BB));
         check($sformatf("%s_dr_order%0d", tag, i), dr_outs_q[i], i);
      end
      check({tag, "_out_n"}, out_q.size(), MEMSZ);
      for (int i = 0; i < out_q.size() && i < MEMSZ; i++)
         check($sformatf("%s_out%0d", tag, i), out_q[i], result_mem[i]);
      check({tag, "_stall_stable"}, stall_viol, 0);
      check({tag, "_done_once"}, done_count, 1);
      check({tag, "_end_state"}, {bus.busy, bus.err}, 2'b00);
   endtask

   initial begin
      int n1;
      int acc;
      int n;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // happy path: status 1 then 0
      status_q = '{1'b1, 1'b0};
      run_job("happy", 32'd8, 1'b0, 0, 1'b0);
      check_job("happy", 2);

      // size mismatch
      status_q.delete();
      run_job("size", 32'd4, 1'b0, 0, 1'b0);
      check("size_err_busy", {bus.err, bus.busy}, 2'b10);
      check("size_no_dw", dw_addr_q.size(), 0);
      check("size_reads", size_reads, 1);
      check("size_no_done", done_count, 0);

      // backpressure with a random number of busy polls
      n1 = $urandom_range(0, 2);
      status_q.delete();
      for (int i = 0; i < n1; i++) status_q.push_back(1'b1);
      status_q.push_back(1'b0);
      run_job("bp", 32'd8, 1'b1, 5, 1'b0);
      check_job("bp", n1 + 1);

      // poll timeout, then the next start clears err
      status_q.delete();
      status_stuck = 1'b1;
      run_job("tmo", 32'd8, 1'b0, 0, 1'b0);
      check("tmo_polls", poll_count, POLL_MAX);
      check("tmo_err_busy", {bus.err, bus.busy}, 2'b10);
      check("tmo_no_done", done_count, 0);
      check("tmo_no_dr", dr_addr_q.size(), 0);
      status_stuck = 1'b0;
      status_q = '{1'b0};
      run_job("after_tmo", 32'd8, 1'b1, 0, 1'b0);
      check_job("after_tmo", 1);

      // reset while loading B
      make_payload();
      size_val = 32'd8;
      status_q = '{1'b0};
      clear_logs();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      acc = 0;
      n = 0;
      while (acc < MEMSZ + 1 && n < 200) begin
         @(negedge clk);
         n++;
         bus.in_valid = 1'b1;
         bus.in_data  = in_q[0];
         #1;
         if (bus.in_valid && bus.in_ready) begin
            void'(in_q.pop_front());
            acc++;
         end
      end
      check("rstmid_reached_b", acc, MEMSZ + 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check_outputs_zero("rstmid");
      clear_logs();
      repeat (10) @(negedge clk);
      check("rstmid_no_req", dw_addr_q.size() + mw_addr_q.size() + dr_addr_q.size() + poll_count + size_reads, 0);
      check("rstmid_idle", {bus.busy, bus.done, bus.err}, 3'b000);
      status_q = '{1'b1, 1'b0};
      run_job("fresh", 32'd8, 1'b0, 0, 1'b0);
      check_job("fresh", 2);

      // start pulsed while polling is ignored
      status_q = '{1'b1, 1'b1, 1'b0};
      run_job("poke", 32'd8, 1'b0, 2, 1'b1);
      check_job("poke", 3);
      repeat (5) @(negedge clk);
      check("poke_idle_after", {bus.busy, done_count}, {1'b0, 32'd1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
